// File: rtl/riscv_types.sv
// Shared RISC-V pipeline types.
//   aluop_t    : ALU operation code produced by decode, consumed by execute.
//   fwd_sel_t  : source chosen by an operand forwarding unit.
package riscv_types;

  typedef enum logic [3:0] {
    alu_add  = 4'd0,
    alu_sub  = 4'd1,
    alu_sll  = 4'd2,
    alu_slt  = 4'd3,
    alu_sltu = 4'd4,
    alu_xor  = 4'd5,
    alu_srl  = 4'd6,
    alu_sra  = 4'd7,
    alu_or   = 4'd8,
    alu_and  = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/fwd_unit.sv
// Combinational operand forwarding for one source register.
//   rs_addr/rs_data         : source address and the value held for it
//   exmem_rd/wr/data        : EX/MEM destination, write flag, result
//   memwb_rd/wr/data        : MEM/WB destination, write flag, result
//   fwd_data                : operand value after forwarding
//   fwd_sel                 : which source supplied fwd_data
// EX/MEM is younger than MEM/WB, so it wins. x0 is never forwarded.
module fwd_unit
  import riscv_types::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic [RADDR-1:0] rs_addr,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic             exmem_wr,
  input  logic [WIDTH-1:0] exmem_data,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic             memwb_wr,
  input  logic [WIDTH-1:0] memwb_data,
  output logic [WIDTH-1:0] fwd_data,
  output fwd_sel_t         fwd_sel
);

  always_comb begin
    fwd_sel  = FWD_NONE;
    fwd_data = rs_data;
    if (rs_addr != '0) begin
      if (exmem_wr && (exmem_rd == rs_addr)) begin
        fwd_sel  = FWD_EXMEM;
        fwd_data = exmem_data;
      end else if (memwb_wr && (memwb_rd == rs_addr)) begin
        fwd_sel  = FWD_MEMWB;
        fwd_data = memwb_data;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-entry valid/ready buffer between decode and
// the execute-stage ALU, with RAW-hazard forwarding from EX/MEM and MEM/WB.
//   clk_in, rst_in (sync, active-high), flush_in
//   decode side : valid_in/ready_out, aluop_in, rs1/rs2 addr+data, imm_in,
//                 use_imm_in, rd_addr_in, reg_write_in
//   later stages: exmem_rd/wr/data_in, memwb_rd/wr/data_in
//   execute side: valid_out/ready_in, alu_ctrl_out, alu_a_out, alu_b_out,
//                 store_data_out, rd_addr_out, reg_write_out
module id_ex_stage
  import riscv_types::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  aluop_t           aluop_in,
  input  logic [RADDR-1:0] rs1_addr_in,
  input  logic [RADDR-1:0] rs2_addr_in,
  input  logic [WIDTH-1:0] rs1_data_in,
  input  logic [WIDTH-1:0] rs2_data_in,
  input  logic [WIDTH-1:0] imm_in,
  input  logic             use_imm_in,
  input  logic [RADDR-1:0] rd_addr_in,
  input  logic             reg_write_in,
  input  logic [RADDR-1:0] exmem_rd_in,
  input  logic [RADDR-1:0] memwb_rd_in,
  input  logic             exmem_wr_in,
  input  logic             memwb_wr_in,
  input  logic [WIDTH-1:0] exmem_data_in,
  input  logic [WIDTH-1:0] memwb_data_in,
  output logic             valid_out,
  input  logic             ready_in,
  output aluop_t           alu_ctrl_out,
  output logic [WIDTH-1:0] alu_a_out,
  output logic [WIDTH-1:0] alu_b_out,
  output logic [WIDTH-1:0] store_data_out,
  output logic [RADDR-1:0] rd_addr_out,
  output logic             reg_write_out
);

  logic             valid_q;
  aluop_t           aluop_q;
  logic [RADDR-1:0] rs1_addr_q, rs2_addr_q, rd_q;
  logic [WIDTH-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic             use_imm_q, reg_write_q;

  logic             capture;
  logic [WIDTH-1:0] rs1_wt, rs2_wt;
  logic [WIDTH-1:0] rs1_fwd, rs2_fwd;
  fwd_sel_t         rs1_sel, rs2_sel;

  assign ready_out = !valid_q || ready_in;
  assign capture   = valid_in && ready_out && !flush_in;

  // Register-file write-through: MEM/WB writes this cycle are not yet
  // visible in the read data presented by decode.
  always_comb begin
    rs1_wt = rs1_data_in;
    rs2_wt = rs2_data_in;
    if (memwb_wr_in && (memwb_rd_in == rs1_addr_in) && (rs1_addr_in != '0))
      rs1_wt = memwb_data_in;
    if (memwb_wr_in && (memwb_rd_in == rs2_addr_in) && (rs2_addr_in != '0))
      rs2_wt = memwb_data_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q     <= 1'b0;
      aluop_q     <= alu_add;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else if (flush_in) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q     <= 1'b1;
      aluop_q     <= aluop_in;
      rs1_addr_q  <= rs1_addr_in;
      rs2_addr_q  <= rs2_addr_in;
      rs1_data_q  <= rs1_wt;
      rs2_data_q  <= rs2_wt;
      imm_q       <= imm_in;
      use_imm_q   <= use_imm_in;
      rd_q        <= rd_addr_in;
      reg_write_q <= reg_write_in;
    end else if (valid_q && ready_in) begin
      valid_q <= 1'b0;
    end else if (valid_q) begin
      // Stalled: absorb MEM/WB results before they retire past this stage,
      // since the forwarding window closes once the writer leaves MEM/WB.
      if (memwb_wr_in && (memwb_rd_in == rs1_addr_q) && (rs1_addr_q != '0))
        rs1_data_q <= memwb_data_in;
      if (memwb_wr_in && (memwb_rd_in == rs2_addr_q) && (rs2_addr_q != '0))
        rs2_data_q <= memwb_data_in;
    end
  end

  fwd_unit #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs1 (
    .rs_addr   (rs1_addr_q),
    .rs_data   (rs1_data_q),
    .exmem_rd  (exmem_rd_in),
    .exmem_wr  (exmem_wr_in),
    .exmem_data(exmem_data_in),
    .memwb_rd  (memwb_rd_in),
    .memwb_wr  (memwb_wr_in),
    .memwb_data(memwb_data_in),
    .fwd_data  (rs1_fwd),
    .fwd_sel   (rs1_sel)
  );

  fwd_unit #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs2 (
    .rs_addr   (rs2_addr_q),
    .rs_data   (rs2_data_q),
    .exmem_rd  (exmem_rd_in),
    .exmem_wr  (exmem_wr_in),
    .exmem_data(exmem_data_in),
    .memwb_rd  (memwb_rd_in),
    .memwb_wr  (memwb_wr_in),
    .memwb_data(memwb_data_in),
    .fwd_data  (rs2_fwd),
    .fwd_sel   (rs2_sel)
  );

  always_comb begin
    alu_a_out      = (rs1_sel == FWD_NONE) ? rs1_data_q : rs1_fwd;
    store_data_out = (rs2_sel == FWD_NONE) ? rs2_data_q : rs2_fwd;
    alu_b_out      = use_imm_q ? imm_q : store_data_out;
  end

  assign valid_out     = valid_q;
  assign alu_ctrl_out  = aluop_q;
  assign rd_addr_out   = rd_q;
  assign reg_write_out = reg_write_q && valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by a
// randomized run, compared against a queue-based reference model.
module tb_id_ex_stage;
  import riscv_types::*;

  logic        clk = 1'b0;
  logic        rst, flush, valid_in, ready_in, use_imm, reg_write;
  aluop_t      aluop;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, exmem_rd, memwb_rd;
  logic [31:0] rs1_data, rs2_data, imm, exmem_data, memwb_data;
  logic        exmem_wr, memwb_wr;
  logic        ready_out, valid_out, reg_write_out;
  aluop_t      alu_ctrl;
  logic [31:0] alu_a, alu_b, store_data;
  logic [4:0]  rd_out;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(32), .RADDR(5)) dut (
    .clk_in(clk), .rst_in(rst), .flush_in(flush), .valid_in(valid_in),
    .ready_out(ready_out), .aluop_in(aluop),
    .rs1_addr_in(rs1_addr), .rs2_addr_in(rs2_addr),
    .rs1_data_in(rs1_data), .rs2_data_in(rs2_data),
    .imm_in(imm), .use_imm_in(use_imm), .rd_addr_in(rd_addr),
    .reg_write_in(reg_write),
    .exmem_rd_in(exmem_rd), .memwb_rd_in(memwb_rd),
    .exmem_wr_in(exmem_wr), .memwb_wr_in(memwb_wr),
    .exmem_data_in(exmem_data), .memwb_data_in(memwb_data),
    .valid_out(valid_out), .ready_in(ready_in), .alu_ctrl_out(alu_ctrl),
    .alu_a_out(alu_a), .alu_b_out(alu_b), .store_data_out(store_data),
    .rd_addr_out(rd_out), .reg_write_out(reg_write_out)
  );

  // Reference model: the stage is a queue holding at most one instruction.
  typedef struct {
    aluop_t      op;
    logic [4:0]  a1, a2, rd;
    logic [31:0] d1, d2, imm;
    logic        ui, rw;
  } ent_t;
  ent_t held[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Value a register read sees given the in-flight writers: youngest wins.
  function automatic logic [31:0] latest(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return rf;
    if (exmem_wr && exmem_rd == a) return exmem_data;
    if (memwb_wr && memwb_rd == a) return memwb_data;
    return rf;
  endfunction

  function automatic logic [31:0] wb_view(input logic [4:0] a, input logic [31:0] rf);
    if (a != 0 && memwb_wr && memwb_rd == a) return memwb_data;
    return rf;
  endfunction

  task automatic model_check();
    bit occ;
    occ = (held.size() != 0);
    check("ready_out", 32'(ready_out), 32'(!occ || ready_in));
    check("valid_out", 32'(valid_out), 32'(occ));
    check("reg_write_out", 32'(reg_write_out), occ ? 32'(held[0].rw) : 32'd0);
    if (occ) begin
      check("alu_ctrl", 32'(alu_ctrl), 32'(held[0].op));
      check("rd_addr_out", 32'(rd_out), 32'(held[0].rd));
      check("alu_a", alu_a, latest(held[0].a1, held[0].d1));
      check("store_data", store_data, latest(held[0].a2, held[0].d2));
      check("alu_b", alu_b, held[0].ui ? held[0].imm : latest(held[0].a2, held[0].d2));
    end
  endtask

  task automatic model_update();
    ent_t e;
    bit occ;
    occ = (held.size() != 0);
    if (rst || flush) begin
      held.delete();
    end else if (valid_in && (!occ || ready_in)) begin
      e.op = aluop; e.a1 = rs1_addr; e.a2 = rs2_addr; e.rd = rd_addr;
      e.d1 = wb_view(rs1_addr, rs1_data); e.d2 = wb_view(rs2_addr, rs2_data);
      e.imm = imm; e.ui = use_imm; e.rw = reg_write;
      held.delete();
      held.push_back(e);
    end else if (occ && ready_in) begin
      void'(held.pop_front());
    end else if (occ) begin
      e = held[0];
      e.d1 = wb_view(e.a1, e.d1);
      e.d2 = wb_view(e.a2, e.d2);
      held[0] = e;
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs sampled 4 later.
  task automatic settle();
    #4;
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic issue(input aluop_t op, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2, input logic [4:0] rd);
    valid_in = 1'b1; aluop = op;
    rs1_addr = a1; rs1_data = d1; rs2_addr = a2; rs2_data = d2; rd_addr = rd;
    reg_write = 1'b1; use_imm = 1'b0; imm = '0;
  endtask

  task automatic quiet_fwd();
    exmem_wr = 1'b0; memwb_wr = 1'b0;
    exmem_rd = '0; memwb_rd = '0; exmem_data = '0; memwb_data = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    aluop = alu_add; rs1_addr = '0; rs2_addr = '0; rs1_data = '0; rs2_data = '0;
    imm = '0; use_imm = 1'b0; rd_addr = '0; reg_write = 1'b0;
    quiet_fwd();
    #1;
    advance();
    advance();
    rst = 1'b0;

    // Reset state
    settle();
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_regwr", 32'(reg_write_out), 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    check("rst_ctrl", 32'(alu_ctrl), 32'(alu_add));
    check("rst_a", alu_a, 32'd0);
    check("rst_b", alu_b, 32'd0);
    check("rst_store", store_data, 32'd0);

    // Plain add, no hazards
    issue(alu_add, 5'd1, 32'd5, 5'd2, 32'd7, 5'd5);
    advance();
    valid_in = 1'b0;
    settle();
    check("add_valid", 32'(valid_out), 32'd1);
    check("add_ctrl", 32'(alu_ctrl), 32'(alu_add));
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd7);
    advance();

    // EX/MEM beats MEM/WB on the same register
    issue(alu_or, 5'd3, 32'h11, 5'd0, 32'd0, 5'd6);
    ready_in = 1'b0;
    advance();
    valid_in = 1'b0;
    exmem_wr = 1'b1; exmem_rd = 5'd3; exmem_data = 32'hAA;
    memwb_wr = 1'b1; memwb_rd = 5'd3; memwb_data = 32'hBB;
    settle();
    check("fwd_exmem", alu_a, 32'hAA);
    exmem_wr = 1'b0;
    #1;
    check("fwd_memwb", alu_a, 32'hBB);
    advance();
    quiet_fwd(); ready_in = 1'b1;
    advance();

    // x0 is never forwarded
    issue(alu_xor, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7);
    exmem_wr = 1'b1; exmem_rd = 5'd0; exmem_data = 32'hFFFF;
    memwb_wr = 1'b1; memwb_rd = 5'd0; memwb_data = 32'hEEEE;
    advance();
    valid_in = 1'b0;
    settle();
    check("x0_a", alu_a, 32'd0);
    check("x0_store", store_data, 32'd0);
    advance();
    quiet_fwd();

    // Stall 3 cycles; MEM/WB writes rs2 in cycle 2 only
    issue(alu_add, 5'd1, 32'd1, 5'd4, 32'd9, 5'd8);
    ready_in = 1'b0;
    advance();
    valid_in = 1'b0;
    settle(); check("stall1_ready", 32'(ready_out), 32'd0);
    advance();
    memwb_wr = 1'b1; memwb_rd = 5'd4; memwb_data = 32'h1234;
    settle(); check("stall2_ready", 32'(ready_out), 32'd0);
    advance();
    memwb_wr = 1'b0;
    settle(); check("stall3_ready", 32'(ready_out), 32'd0);
    check("stall3_store", store_data, 32'h1234);
    advance();
    ready_in = 1'b1;
    settle();
    check("release_valid", 32'(valid_out), 32'd1);
    check("release_store", store_data, 32'h1234);
    advance();

    // Flush drops both the held and the incoming instruction
    issue(alu_sub, 5'd1, 32'd3, 5'd2, 32'd4, 5'd9);
    ready_in = 1'b0;
    advance();
    issue(alu_and, 5'd2, 32'd8, 5'd3, 32'd6, 5'd10);
    flush = 1'b1;
    settle();
    advance();
    flush = 1'b0; valid_in = 1'b0;
    settle();
    check("flush_valid", 32'(valid_out), 32'd0);
    check("flush_ready", 32'(ready_out), 32'd1);
    check("flush_regwr", 32'(reg_write_out), 32'd0);
    advance();

    // Immediate operand with forwarded store data
    issue(alu_sra, 5'd1, 32'd2, 5'd6, 32'h77, 5'd11);
    use_imm = 1'b1; imm = 32'hFFFF_FFF0;
    advance();
    valid_in = 1'b0;
    exmem_wr = 1'b1; exmem_rd = 5'd6; exmem_data = 32'h5555;
    settle();
    check("imm_ctrl", 32'(alu_ctrl), 32'(alu_sra));
    check("imm_b", alu_b, 32'hFFFF_FFF0);
    check("imm_store", store_data, 32'h5555);
    advance();
    quiet_fwd();

    // Reset in the middle of a stall, with flush and capture also asserted
    issue(alu_sll, 5'd1, 32'd1, 5'd2, 32'd2, 5'd12);
    ready_in = 1'b0;
    advance();
    rst = 1'b1; flush = 1'b1; valid_in = 1'b1;
    advance();
    rst = 1'b0; flush = 1'b0; valid_in = 1'b0;
    settle();
    check("rststall_valid", 32'(valid_out), 32'd0);
    check("rststall_ctrl", 32'(alu_ctrl), 32'(alu_add));
    advance();

    // Randomized run; small address space to provoke hazards
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      flush      = ($urandom_range(0, 11) == 0);
      valid_in   = ($urandom_range(0, 3) != 0);
      ready_in   = ($urandom_range(0, 2) != 0);
      aluop      = aluop_t'($urandom_range(0, 9));
      rs1_addr   = 5'($urandom_range(0, 3));
      rs2_addr   = 5'($urandom_range(0, 3));
      rd_addr    = 5'($urandom_range(0, 31));
      rs1_data   = $urandom;
      rs2_data   = $urandom;
      imm        = $urandom;
      use_imm    = $urandom_range(0, 1) == 1;
      reg_write  = $urandom_range(0, 1) == 1;
      exmem_wr   = $urandom_range(0, 1) == 1;
      memwb_wr   = $urandom_range(0, 1) == 1;
      exmem_rd   = 5'($urandom_range(0, 3));
      memwb_rd   = 5'($urandom_range(0, 3));
      exmem_data = $urandom;
      memwb_data = $urandom;
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
